issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 133 +++++++++++++
 tb/tb_issue_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Dual-push, dual-read circular issue queue between decode and issue.
// Optional perf counters enabled with macro ISSUE_QUEUE_PERF_EN.
package issue_queue_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ISSUE_QUEUE_ELEMENT;
endpackage

module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flash,
   input  logic [1:0]            push_num,
   input  ISSUE_QUEUE_ELEMENT [1:0] push_data,
   output logic                  push_ready,
   output ISSUE_QUEUE_ELEMENT [1:0] issue_require,
   output logic [1:0]            iq_size,
   input  logic [1:0]            iq_pop_number
`ifdef ISSUE_QUEUE_PERF_EN
   ,
   output logic [31:0]           perf_full_cycles,
   output logic [31:0]           perf_pop_total
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ISSUE_QUEUE_ELEMENT mem_q [DEPTH];
   ISSUE_QUEUE_ELEMENT mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [PW-1:0] head_p1;
   logic [PW-1:0] tail_p1;
   logic [1:0]    push_cnt;
   logic [1:0]    pop_eff;
   logic          push_ok;

   // Status and read ports derived from registered state only
   always_comb begin
      head_p1    = head_q + PW'(1);
      tail_p1    = tail_q + PW'(1);
      push_cnt   = push_num[1] ? 2'd2 : push_num;
      iq_size    = (occ_q >= CW'(2)) ? 2'd2 : occ_q[1:0];
      push_ready = (occ_q <= CW'(DEPTH - 2));
      pop_eff    = (iq_pop_number < iq_size) ? iq_pop_number : iq_size;
      push_ok    = push_ready && (push_cnt != 2'd0);
      issue_require[0] = (occ_q > CW'(0)) ? mem_q[head_q]  : '0;
      issue_require[1] = (occ_q > CW'(1)) ? mem_q[head_p1] : '0;
   end

   // Next state: flush clears pointers, else pop and push together
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      mem_d  = mem_q;
      if (flash) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         head_d = head_q + PW'(pop_eff);
         occ_d  = occ_q - CW'(pop_eff);
         if (push_ok) begin
            mem_d[tail_q] = push_data[0];
            if (push_cnt == 2'd2) begin
               mem_d[tail_p1] = push_data[1];
            end
            tail_d = tail_q + PW'(push_cnt);
            occ_d  = occ_q - CW'(pop_eff) + CW'(push_cnt);
         end
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Entry storage; contents are don't-care while unoccupied
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q <= mem_d;
      end
   end

`ifdef ISSUE_QUEUE_PERF_EN
   logic [31:0] perf_full_q, perf_full_d;
   logic [31:0] perf_pop_q, perf_pop_d;

   // Count blocked push cycles and entries actually popped
   always_comb begin
      perf_full_d = perf_full_q;
      perf_pop_d  = perf_pop_q;
      if ((push_num != 2'd0) && !push_ready) begin
         perf_full_d = perf_full_q + 32'd1;
      end
      if (!flash) begin
         perf_pop_d = perf_pop_q + 32'(pop_eff);
      end
   end

   // Perf registers survive flush, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_full_q <= '0;
         perf_pop_q  <= '0;
      end else begin
         perf_full_q <= perf_full_d;
         perf_pop_q  <= perf_pop_d;
      end
   end

   assign perf_full_cycles = perf_full_q;
   assign perf_pop_total   = perf_pop_q;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Testbench for issue_queue: vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_issue_queue;
   import issue_queue_pkg::*;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst;
   logic flash;
   logic [1:0] push_num;
   ISSUE_QUEUE_ELEMENT [1:0] push_data;
   logic push_ready;
   ISSUE_QUEUE_ELEMENT [1:0] issue_require;
   logic [1:0] iq_size;
   logic [1:0] iq_pop_number;
`ifdef ISSUE_QUEUE_PERF_EN
   logic [31:0] perf_full_cycles;
   logic [31:0] perf_pop_total;
`endif

   issue_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .flash(flash),
      .push_num(push_num),
      .push_data(push_data),
      .push_ready(push_ready),
      .issue_require(issue_require),
      .iq_size(iq_size),
      .iq_pop_number(iq_pop_number)
`ifdef ISSUE_QUEUE_PERF_EN
      ,
      .perf_full_cycles(perf_full_cycles),
      .perf_pop_total(perf_pop_total)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   ISSUE_QUEUE_ELEMENT mq[$];
   logic [31:0] m_full = '0;
   logic [31:0] m_pop = '0;

   function automatic ISSUE_QUEUE_ELEMENT mk(input int t);
      ISSUE_QUEUE_ELEMENT e;
      if (t == 0) e = '0;
      else e = {32'(t), 32'(t) ^ 32'h5A5A_5A5A};
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Compare DUT against the reference model's view of the queue
   task automatic check_model(input string nm);
      int sz;
      sz = mq.size();
      chk({nm, ".size"}, 64'(iq_size), 64'(sz < 2 ? sz : 2));
      chk({nm, ".ready"}, 64'(push_ready), 64'((DEPTH - sz) >= 2));
      chk({nm, ".r0"}, issue_require[0], sz > 0 ? mq[0] : '0);
      chk({nm, ".r1"}, issue_require[1], sz > 1 ? mq[1] : '0);
`ifdef ISSUE_QUEUE_PERF_EN
      chk({nm, ".pfull"}, 64'(perf_full_cycles), 64'(m_full));
      chk({nm, ".ppop"}, 64'(perf_pop_total), 64'(m_pop));
`endif
   endtask

   // One clock: drive inputs, advance model, check at negedge
   task automatic step(input bit r, input bit fl, input int pn,
                       input ISSUE_QUEUE_ELEMENT d0,
                       input ISSUE_QUEUE_ELEMENT d1, input int pp,
                       input string nm);
      int sz, isz, eff, npush;
      bit rdy;
      rst = r;
      flash = fl;
      push_num = 2'(pn);
      push_data[0] = d0;
      push_data[1] = d1;
      iq_pop_number = 2'(pp);
      sz = mq.size();
      rdy = (DEPTH - sz) >= 2;
      isz = sz < 2 ? sz : 2;
      eff = pp < isz ? pp : isz;
      npush = pn > 2 ? 2 : pn;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_full = '0;
         m_pop = '0;
      end else begin
         if (pn != 0 && !rdy) m_full = m_full + 1;
         if (fl) begin
            mq.delete();
         end else begin
            repeat (eff) void'(mq.pop_front());
            m_pop = m_pop + 32'(eff);
            if (rdy && npush >= 1) mq.push_back(d0);
            if (rdy && npush == 2) mq.push_back(d1);
         end
      end
      @(negedge clk);
      check_model(nm);
   endtask

   task automatic push(input int pn, input int t0, input int t1,
                       input int pp, input string nm);
      step(1'b0, 1'b0, pn, mk(t0), mk(t1), pp, nm);
   endtask

   typedef struct {
      int fl; int pn; int pp; int d0; int d1;
      int esz; int erdy; int e0; int e1;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{0, 2, 0,  1,  2, 2, 1,  1,  2};
      tbl[1]  = '{0, 1, 1,  3,  0, 2, 1,  2,  3};
      tbl[2]  = '{0, 0, 3,  0,  0, 0, 1,  0,  0};
      tbl[3]  = '{0, 1, 0,  4,  0, 1, 1,  4,  0};
      tbl[4]  = '{0, 0, 2,  0,  0, 0, 1,  0,  0};
      tbl[5]  = '{0, 3, 0,  5,  6, 2, 1,  5,  6};
      tbl[6]  = '{0, 2, 0,  7,  8, 2, 1,  5,  6};
      tbl[7]  = '{0, 2, 0,  9, 10, 2, 1,  5,  6};
      tbl[8]  = '{0, 2, 2, 11, 12, 2, 1,  7,  8};
      tbl[9]  = '{0, 2, 0, 13, 14, 2, 0,  7,  8};
      tbl[10] = '{0, 2, 0, 15, 16, 2, 0,  7,  8};
      tbl[11] = '{0, 0, 2,  0,  0, 2, 1,  9, 10};
      tbl[12] = '{1, 2, 1, 17, 18, 0, 1,  0,  0};
      tbl[13] = '{0, 1, 0, 19,  0, 1, 1, 19,  0};

      rst = 1'b1;
      flash = 1'b0;
      push_num = '0;
      push_data = '0;
      iq_pop_number = '0;
      @(negedge clk);

      // Reset state
      step(1'b1, 1'b0, 0, '0, '0, 0, "reset");
      chk("reset.size", 64'(iq_size), 64'd0);
      chk("reset.ready", 64'(push_ready), 64'd1);
      chk("reset.r0", issue_require[0], '0);

      // Vector table
      foreach (tbl[i]) begin
         step(1'b0, tbl[i].fl[0], tbl[i].pn, mk(tbl[i].d0),
              mk(tbl[i].d1), tbl[i].pp, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.tsize", i), 64'(iq_size), 64'(tbl[i].esz));
         chk($sformatf("vec%0d.tready", i), 64'(push_ready),
             64'(tbl[i].erdy));
         chk($sformatf("vec%0d.t0", i), issue_require[0], mk(tbl[i].e0));
         chk($sformatf("vec%0d.t1", i), issue_require[1], mk(tbl[i].e1));
      end

      // Fill to capacity, drop overflow, drain in order
      step(1'b1, 1'b0, 0, '0, '0, 0, "fill.rst");
      for (int i = 0; i < 4; i++)
         push(2, 101 + 2 * i, 102 + 2 * i, 0, "fill.push");
      chk("fill.full_ready", 64'(push_ready), 64'd0);
      push(2, 201, 202, 0, "fill.drop");
      for (int i = 0; i < 8; i++) begin
         chk("fill.order", 64'(issue_require[0].pc), 64'(101 + i));
         push(0, 0, 0, 1, "fill.pop");
      end
      chk("fill.empty", 64'(iq_size), 64'd0);

      // Push of two straddling the pointer wrap
      step(1'b1, 1'b0, 0, '0, '0, 0, "wrap.rst");
      push(1, 300, 0, 0, "wrap.p");
      for (int i = 0; i < 6; i++) push(1, 301 + i, 0, 1, "wrap.pp");
      push(0, 0, 0, 1, "wrap.drain");
      push(2, 400, 401, 0, "wrap.pq");
      chk("wrap.r0", 64'(issue_require[0].pc), 64'd400);
      chk("wrap.r1", 64'(issue_require[1].pc), 64'd401);
      push(2, 402, 403, 1, "wrap.more");
      chk("wrap.after", 64'(issue_require[0].pc), 64'd401);

      // Flush with simultaneous push and pop; perf state retained
      step(1'b1, 1'b0, 0, '0, '0, 0, "fl.rst");
      for (int i = 0; i < 4; i++) push(2, 500 + i, 600 + i, 0, "fl.fill");
      push(2, 700, 701, 0, "fl.block");
      push(0, 0, 0, 2, "fl.pop2");
      push(0, 0, 0, 1, "fl.pop1");
      chk("fl.occ5", 64'(iq_size), 64'd2);
      step(1'b0, 1'b1, 2, mk(800), mk(801), 1, "fl.flash");
      chk("fl.size", 64'(iq_size), 64'd0);
      chk("fl.ready", 64'(push_ready), 64'd1);
`ifdef ISSUE_QUEUE_PERF_EN
      chk("fl.pfull", 64'(perf_full_cycles), 64'd1);
      chk("fl.ppop", 64'(perf_pop_total), 64'd3);
`endif

      // Reset mid-operation drops a same-cycle push
      push(2, 900, 901, 0, "mid.push");
      step(1'b1, 1'b0, 2, mk(902), mk(903), 0, "mid.rst");
      chk("mid.size", 64'(iq_size), 64'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         bit r, fl;
         r = ($urandom_range(0, 99) == 0);
         fl = ($urandom_range(0, 29) == 0);
         step(r, fl, int'($urandom_range(0, 3)),
              mk(int'($urandom | 1)), mk(int'($urandom | 1)),
              int'($urandom_range(0, 3)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
